// File: rtl/rvm_test_monitor.sv
// rvm_test_monitor
//   Run-control and completion monitor placed beside a core on the
//   instruction-fetch bus. It compares each accepted fetch address against
//   NUM_WATCH programmable watch entries (halt / pass / fail), counts run
//   cycles and valid fetches, applies a programmable cycle timeout, and
//   latches a single sticky verdict.
//
// Ports
//   clk          core clock, rising-edge active
//   reset        asynchronous active-high reset
//   clear        synchronous clear back to IDLE with counters/verdict zeroed
//   enable       run gate; counting and triggering only while high in RUN
//   mon_valid    fetch address valid (accepted) this cycle
//   mon_addr     fetch address
//   watch_addr   flattened watch addresses, entry k at [k*ADDR_W +: ADDR_W]
//   watch_kind   per entry 2 bits: 00 off, 01 halt, 10 pass, 11 fail
//   max_cycles   RUN-cycle limit, 0 disables the timeout
//   running      FSM in RUN
//   finished     FSM in DONE
//   pass/fail/halt/timeout  one-hot sticky verdict flags
//   cause_idx    triggering watch entry, 0 on timeout
//   cycle_count  RUN cycles elapsed (saturating)
//   fetch_count  valid fetches seen in RUN (saturating)
//
// FSM states
//   state   | meaning
//   IDLE    | not running, counters frozen (reset/clear or paused)
//   RUN     | counting cycles/fetches, watching for triggers
//   DONE    | verdict latched, sticky until reset or clear

module rvm_test_monitor #(
  parameter int ADDR_W    = 32,
  parameter int NUM_WATCH = 4,
  parameter int IDX_W     = 2,
  parameter int CNT_W     = 32,
  parameter int HIT_COUNT = 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        clear,
  input  logic                        enable,
  input  logic                        mon_valid,
  input  logic [ADDR_W-1:0]           mon_addr,
  input  logic [NUM_WATCH*ADDR_W-1:0] watch_addr,
  input  logic [NUM_WATCH*2-1:0]      watch_kind,
  input  logic [CNT_W-1:0]            max_cycles,
  output logic                        running,
  output logic                        finished,
  output logic                        pass,
  output logic                        fail,
  output logic                        halt,
  output logic                        timeout,
  output logic [IDX_W-1:0]            cause_idx,
  output logic [CNT_W-1:0]            cycle_count,
  output logic [CNT_W-1:0]            fetch_count
);

  localparam logic [1:0] KIND_OFF  = 2'b00;
  localparam logic [1:0] KIND_HALT = 2'b01;
  localparam logic [1:0] KIND_PASS = 2'b10;
  localparam logic [1:0] KIND_FAIL = 2'b11;

  localparam logic [7:0] HIT_TARGET = 8'(HIT_COUNT);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  logic             active;
  logic             match_hit;
  logic [IDX_W-1:0] match_idx;
  logic [1:0]       match_kind;
  logic [7:0]       streak_cnt;
  logic [7:0]       streak_cnt_next;
  logic [IDX_W-1:0] streak_idx;
  logic [IDX_W-1:0] streak_idx_next;
  logic             watch_fire;
  logic             timeout_fire;

  // A RUN cycle with enable low is the pause cycle: it neither counts nor
  // triggers, it only takes the FSM back to IDLE.
  assign active = (state == ST_RUN) && enable;

  // Scan from the top entry down so the lowest matching index is the one
  // left standing; duplicate addresses resolve to the lower entry.
  always_comb begin
    match_hit  = 1'b0;
    match_idx  = '0;
    match_kind = KIND_OFF;
    for (int k = NUM_WATCH - 1; k >= 0; k--) begin
      if ((watch_kind[k*2 +: 2] != KIND_OFF) &&
          (mon_addr == watch_addr[k*ADDR_W +: ADDR_W])) begin
        match_hit  = 1'b1;
        match_idx  = IDX_W'(k);
        match_kind = watch_kind[k*2 +: 2];
      end
    end
  end

  // Streak of consecutive valid fetches on the same entry. Stall cycles
  // hold it so a stalled fetch does not break the run of hits.
  always_comb begin
    streak_cnt_next = streak_cnt;
    streak_idx_next = streak_idx;
    if (active && mon_valid) begin
      if (match_hit) begin
        if ((match_idx == streak_idx) && (streak_cnt != 8'd0)) begin
          if (streak_cnt != 8'hFF) begin
            streak_cnt_next = streak_cnt + 8'd1;
          end
        end else begin
          streak_cnt_next = 8'd1;
          streak_idx_next = match_idx;
        end
      end else begin
        streak_cnt_next = 8'd0;
      end
    end
  end

  assign watch_fire   = active && mon_valid && match_hit &&
                        (streak_cnt_next == HIT_TARGET);
  // Compare against max_cycles-1 so the limit-th RUN cycle is the last one
  // counted and the final count equals max_cycles.
  assign timeout_fire = active && (max_cycles != '0) &&
                        (cycle_count == (max_cycles - CNT_W'(1)));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else if (clear) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (enable) begin
          state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        if (watch_fire || timeout_fire) begin
          state_next = ST_DONE;
        end else if (!enable) begin
          state_next = ST_IDLE;
        end
      end
      ST_DONE: begin
        state_next = ST_DONE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycle_count <= '0;
      fetch_count <= '0;
      streak_cnt  <= 8'd0;
      streak_idx  <= '0;
    end else if (clear) begin
      cycle_count <= '0;
      fetch_count <= '0;
      streak_cnt  <= 8'd0;
      streak_idx  <= '0;
    end else begin
      streak_cnt <= streak_cnt_next;
      streak_idx <= streak_idx_next;
      if (active) begin
        if (cycle_count != '1) begin
          cycle_count <= cycle_count + CNT_W'(1);
        end
        if (mon_valid && (fetch_count != '1)) begin
          fetch_count <= fetch_count + CNT_W'(1);
        end
      end
    end
  end

  // Watch trigger outranks a coincident timeout; only one flag is ever set
  // because the FSM leaves RUN on the same edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pass      <= 1'b0;
      fail      <= 1'b0;
      halt      <= 1'b0;
      timeout   <= 1'b0;
      cause_idx <= '0;
    end else if (clear) begin
      pass      <= 1'b0;
      fail      <= 1'b0;
      halt      <= 1'b0;
      timeout   <= 1'b0;
      cause_idx <= '0;
    end else if (watch_fire) begin
      cause_idx <= match_idx;
      pass      <= (match_kind == KIND_PASS);
      fail      <= (match_kind == KIND_FAIL);
      halt      <= (match_kind == KIND_HALT);
    end else if (timeout_fire) begin
      cause_idx <= '0;
      timeout   <= 1'b1;
    end
  end

  assign running  = (state == ST_RUN);
  assign finished = (state == ST_DONE);

endmodule

// File: tb/tb_rvm_test_monitor.sv
// Directed bench for rvm_test_monitor. Two instances share one stimulus:
// d1 uses HIT_COUNT=1, d3 uses HIT_COUNT=3. Expected snapshots are queued
// as stimulus is applied and compared after the following clock edge.

module tb_rvm_test_monitor;

  logic         clk = 1'b0;
  logic         reset;
  logic         clear;
  logic         enable;
  logic         mon_valid;
  logic [31:0]  mon_addr;
  logic [127:0] watch_addr;
  logic [7:0]   watch_kind;
  logic [31:0]  max_cycles;

  logic        d1_running, d1_finished, d1_pass, d1_fail, d1_halt, d1_timeout;
  logic [1:0]  d1_cause;
  logic [31:0] d1_cycles, d1_fetches;
  logic        d3_running, d3_finished, d3_pass, d3_fail, d3_halt, d3_timeout;
  logic [1:0]  d3_cause;
  logic [31:0] d3_cycles, d3_fetches;

  rvm_test_monitor #(.ADDR_W(32), .NUM_WATCH(4), .IDX_W(2), .CNT_W(32), .HIT_COUNT(1)) d1 (
    .clk(clk), .reset(reset), .clear(clear), .enable(enable),
    .mon_valid(mon_valid), .mon_addr(mon_addr),
    .watch_addr(watch_addr), .watch_kind(watch_kind), .max_cycles(max_cycles),
    .running(d1_running), .finished(d1_finished), .pass(d1_pass), .fail(d1_fail),
    .halt(d1_halt), .timeout(d1_timeout), .cause_idx(d1_cause),
    .cycle_count(d1_cycles), .fetch_count(d1_fetches)
  );

  rvm_test_monitor #(.ADDR_W(32), .NUM_WATCH(4), .IDX_W(2), .CNT_W(32), .HIT_COUNT(3)) d3 (
    .clk(clk), .reset(reset), .clear(clear), .enable(enable),
    .mon_valid(mon_valid), .mon_addr(mon_addr),
    .watch_addr(watch_addr), .watch_kind(watch_kind), .max_cycles(max_cycles),
    .running(d3_running), .finished(d3_finished), .pass(d3_pass), .fail(d3_fail),
    .halt(d3_halt), .timeout(d3_timeout), .cause_idx(d3_cause),
    .cycle_count(d3_cycles), .fetch_count(d3_fetches)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    bit          sel3;
    logic [71:0] vec;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  function automatic logic [71:0] observe(bit sel3);
    if (sel3)
      return {d3_running, d3_finished, d3_pass, d3_fail, d3_halt, d3_timeout,
              d3_cause, d3_cycles, d3_fetches};
    return {d1_running, d1_finished, d1_pass, d1_fail, d1_halt, d1_timeout,
            d1_cause, d1_cycles, d1_fetches};
  endfunction

  // fields: running finished pass fail halt timeout cause cycles fetches
  task automatic expect_out(input string tag, input bit sel3,
                            input logic r, input logic f, input logic p,
                            input logic fl, input logic h, input logic t,
                            input logic [1:0] c, input logic [31:0] cy,
                            input logic [31:0] fc);
    exp_t e;
    e.tag  = tag;
    e.sel3 = sel3;
    e.vec  = {r, f, p, fl, h, t, c, cy, fc};
    sb.push_back(e);
  endtask

  task automatic check_sb();
    exp_t        e;
    logic [71:0] o;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      o = observe(e.sel3);
      checks++;
      assert (o === e.vec) else begin
        failures++;
        $error("FAIL %s observed=%h expected=%h", e.tag, o, e.vec);
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_watch(input int k, input logic [31:0] a, input logic [1:0] kind);
    watch_addr[k*32 +: 32] = a;
    watch_kind[k*2 +: 2]   = kind;
  endtask

  task automatic do_clear();
    clear     = 1'b1;
    mon_valid = 1'b0;
    expect_out("clear", 0, 0, 0, 0, 0, 0, 0, 2'd0, 32'd0, 32'd0);
    expect_out("clear3", 1, 0, 0, 0, 0, 0, 0, 2'd0, 32'd0, 32'd0);
    step();
    check_sb();
    clear      = 1'b0;
    watch_kind = '0;
    watch_addr = '0;
  endtask

  initial begin
    logic        stay_bad;
    logic [31:0] fcnt;
    logic        sv[7];
    logic [31:0] sa[7];

    reset      = 1'b1;
    clear      = 1'b0;
    enable     = 1'b0;
    mon_valid  = 1'b0;
    mon_addr   = '0;
    watch_addr = '0;
    watch_kind = '0;
    max_cycles = '0;
    #1;
    expect_out("reset", 0, 0, 0, 0, 0, 0, 0, 2'd0, 32'd0, 32'd0);
    check_sb();
    #12;
    reset = 1'b0;

    // pass path
    set_watch(1, 32'h100, 2'b10);
    enable = 1'b1;
    expect_out("p_run", 0, 1, 0, 0, 0, 0, 0, 2'd0, 32'd0, 32'd0);
    step(); check_sb();
    mon_valid = 1'b1; mon_addr = 32'h0;
    expect_out("p_f1", 0, 1, 0, 0, 0, 0, 0, 2'd0, 32'd1, 32'd1);
    step(); check_sb();
    mon_addr = 32'h4;
    expect_out("p_f2", 0, 1, 0, 0, 0, 0, 0, 2'd0, 32'd2, 32'd2);
    step(); check_sb();
    mon_addr = 32'h100;
    expect_out("p_done", 0, 0, 1, 1, 0, 0, 0, 2'd1, 32'd3, 32'd3);
    step(); check_sb();

    // timeout at 5
    do_clear();
    max_cycles = 32'd5;
    expect_out("t_run", 0, 1, 0, 0, 0, 0, 0, 2'd0, 32'd0, 32'd0);
    step(); check_sb();
    mon_valid = 1'b1; mon_addr = 32'h40;
    for (int i = 1; i <= 5; i++) begin
      expect_out("t_cnt", 0, (i < 5), (i == 5), 0, 0, 0, (i == 5), 2'd0, 32'(i), 32'(i));
      if (i == 5)
        expect_out("t_done3", 1, 0, 1, 0, 0, 0, 1, 2'd0, 32'd5, 32'd5);
      step(); check_sb();
    end

    // timeout disabled
    do_clear();
    max_cycles = 32'd0;
    step();
    stay_bad = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      step();
      if (!d1_running || d1_finished) stay_bad = 1'b1;
    end
    checks++;
    assert (stay_bad === 1'b0) else begin
      failures++;
      $error("FAIL nolimit_stay observed=%b expected=0", stay_bad);
    end
    expect_out("nolimit", 0, 1, 0, 0, 0, 0, 0, 2'd0, 32'd1000, 32'd0);
    check_sb();

    // watch beats timeout, lowest index wins
    do_clear();
    set_watch(0, 32'h200, 2'b11);
    set_watch(2, 32'h200, 2'b10);
    max_cycles = 32'd4;
    step();
    mon_valid = 1'b1; mon_addr = 32'h10;
    step(); step(); step();
    expect_out("prio_pre", 0, 1, 0, 0, 0, 0, 0, 2'd0, 32'd3, 32'd3);
    check_sb();
    mon_addr = 32'h200;
    expect_out("prio", 0, 0, 1, 0, 1, 0, 0, 2'd0, 32'd4, 32'd4);
    expect_out("prio3_tmo", 1, 0, 1, 0, 0, 0, 1, 2'd0, 32'd4, 32'd4);
    step(); check_sb();

    // streak with HIT_COUNT=3
    do_clear();
    max_cycles = 32'd0;
    set_watch(1, 32'h300, 2'b01);
    step();
    sv = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    sa = '{32'h300, 32'h300, 32'h300, 32'h304, 32'h300, 32'h300, 32'h300};
    fcnt = 32'd0;
    for (int j = 0; j < 7; j++) begin
      mon_valid = sv[j];
      mon_addr  = sa[j];
      fcnt      = fcnt + 32'(sv[j]);
      expect_out("streak", 1, (j < 6), (j == 6), 0, 0, (j == 6), 0,
                 (j == 6) ? 2'd1 : 2'd0, 32'(j + 1), fcnt);
      step(); check_sb();
    end

    // pause, resume, sticky DONE, clear
    do_clear();
    set_watch(1, 32'h100, 2'b10);
    step();
    mon_valid = 1'b1; mon_addr = 32'h40;
    step(); step();
    enable = 1'b0; mon_addr = 32'h100;
    for (int i = 0; i < 4; i++) begin
      expect_out("pause", 0, 0, 0, 0, 0, 0, 0, 2'd0, 32'd2, 32'd2);
      step(); check_sb();
    end
    enable = 1'b1; mon_valid = 1'b0;
    expect_out("resume", 0, 1, 0, 0, 0, 0, 0, 2'd0, 32'd2, 32'd2);
    step(); check_sb();
    mon_valid = 1'b1;
    expect_out("resume_pass", 0, 0, 1, 1, 0, 0, 0, 2'd1, 32'd3, 32'd3);
    step(); check_sb();
    set_watch(2, 32'h200, 2'b11);
    for (int i = 0; i < 4; i++) begin
      enable   = i[0];
      mon_addr = i[0] ? 32'h200 : 32'h100;
      expect_out("sticky", 0, 0, 1, 1, 0, 0, 0, 2'd1, 32'd3, 32'd3);
      step(); check_sb();
    end
    enable = 1'b1;
    do_clear();

    // async reset between edges
    mon_valid = 1'b1; mon_addr = 32'h40;
    step(); step(); step();
    expect_out("ar_pre", 0, 1, 0, 0, 0, 0, 0, 2'd0, 32'd2, 32'd2);
    check_sb();
    #3;
    reset = 1'b1;
    #1;
    expect_out("ar_immediate", 0, 0, 0, 0, 0, 0, 0, 2'd0, 32'd0, 32'd0);
    check_sb();
    step();
    reset = 1'b0;
    expect_out("ar_held", 0, 0, 0, 0, 0, 0, 0, 2'd0, 32'd0, 32'd0);
    check_sb();
    expect_out("ar_rerun", 0, 1, 0, 0, 0, 0, 0, 2'd0, 32'd0, 32'd0);
    step(); check_sb();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rvm_test_monitor.md
Name: rvm_test_monitor

Overview:
- Synthesisable run-control and completion monitor for core-level simulation and FPGA bring-up.
- Watches the instruction-fetch address stream against NUM_WATCH programmable watch entries. Each entry is a halt, pass or fail point.
- Counts run cycles and retired fetches, and applies a runtime-programmable cycle timeout.
- Reports one sticky, registered verdict. Sits beside the core on the instruction memory bus and replaces bench-side address checking.

Parameters:
- ADDR_W, 32, width of fetch and watch addresses.
- NUM_WATCH, 4, number of watch entries (1..16).
- IDX_W, 2, width of cause_idx; must be at least clog2(NUM_WATCH), minimum 1.
- CNT_W, 32, width of cycle and fetch counters.
- HIT_COUNT, 1, number of consecutive valid fetches at the same matching entry required to trigger (1..255). Values >1 filter transient speculative fetches.

Ports:
- clk  in  1  core clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-high reset.
- clear  in  1  synchronous clear: state to IDLE, counters and verdict zeroed.
- enable  in  1  run gate; monitor counts only while high.
- mon_valid  in  1  fetch address valid this cycle (request accepted, not stalled).
- mon_addr  in  ADDR_W  fetch address.
- watch_addr  in  NUM_WATCH*ADDR_W  flattened watch addresses; entry k at bits [k*ADDR_W +: ADDR_W].
- watch_kind  in  NUM_WATCH*2  per entry: 00 disabled, 01 halt, 10 pass, 11 fail.
- max_cycles  in  CNT_W  timeout limit; 0 disables timeout.
- running  out  1  state is RUN.
- finished  out  1  state is DONE.
- pass  out  1  verdict: pass entry hit.
- fail  out  1  verdict: fail entry hit.
- halt  out  1  verdict: halt entry hit.
- timeout  out  1  verdict: cycle limit reached.
- cause_idx  out  IDX_W  index of the triggering entry; 0 on timeout.
- cycle_count  out  CNT_W  RUN cycles elapsed.
- fetch_count  out  CNT_W  valid fetches observed in RUN.

Behaviour:
- Reset (async) or clear (sync):
  - state = IDLE.
  - All outputs 0, cycle_count = 0, fetch_count = 0.
  - Hit streak counter = 0, streak entry = 0.
  - clear takes priority over every other input. reset has highest priority overall.
- FSM states IDLE, RUN, DONE:
  - IDLE -> RUN when enable = 1.
  - RUN -> IDLE when enable = 0. Counters and streak hold, giving a pause/resume.
  - RUN -> DONE on trigger.
  - DONE is sticky. Only reset or clear leaves it. enable is ignored in DONE.
- Counters (RUN cycles only):
  - cycle_count += 1 each RUN cycle.
  - fetch_count += 1 each RUN cycle with mon_valid = 1.
  - Both saturate at all-ones and never wrap.
  - Counters freeze in IDLE and DONE. The triggering cycle is counted.
- Match, evaluated combinationally in RUN when mon_valid = 1:
  - Entry k matches if watch_kind[k] != 00 and mon_addr == watch_addr[k].
  - The lowest-index matching entry wins, so duplicate addresses resolve to the lower index.
- Streak counter (width 8):
  - Valid fetch matching the same entry as the current streak: streak += 1, saturating.
  - Valid fetch matching a different entry: streak restarts at 1 with the new entry.
  - Valid non-matching fetch: streak = 0.
  - mon_valid = 0 cycles: streak holds.
- Watch trigger:
  - Fires in the RUN cycle where the post-update streak equals HIT_COUNT.
  - At the next edge: state = DONE, cause_idx = entry, and the flag for that entry's kind is set.
  - Exactly one of pass/fail/halt/timeout is 1 in DONE.
- Timeout trigger:
  - Fires in the RUN cycle where max_cycles != 0 and cycle_count == max_cycles - 1, i.e. the max_cycles-th RUN cycle.
  - At the next edge: DONE, timeout = 1, cause_idx = 0.
- Simultaneous watch trigger and timeout in the same cycle: watch wins, timeout stays 0.
- Latency:
  - Verdict outputs are registered and visible 1 cycle after the qualifying fetch.
  - running and finished are decoded from registered state.
- Configuration: watch_addr, watch_kind and max_cycles are sampled live each cycle. Changing them mid-RUN takes effect immediately; the streak is not reset.
- Reset asserted mid-RUN or in DONE: immediate return to the reset values above. No verdict is retained.

Test Plan:
- Pass path: reset, enable = 1, entry 1 = {0x0000_0100, pass}, HIT_COUNT = 1, valid fetches 0x0, 0x4, 0x100 -> next cycle finished = 1, pass = 1, cause_idx = 1, fetch_count = 3, cycle_count = 3.
- Timeout and disable: max_cycles = 5, no matching fetches -> timeout = 1 after the 5th RUN edge, cycle_count = 5. Repeat with max_cycles = 0 for 1000 cycles -> running stays 1, finished stays 0.
- Priority: entries 0 and 2 both = 0x200 with kinds fail and pass; fetch 0x200 on the same cycle cycle_count reaches max_cycles - 1 -> fail = 1, cause_idx = 0, timeout = 0.
- Streak: HIT_COUNT = 3, fetch sequence 0x300 (halt entry), stall, 0x300, 0x304, 0x300, 0x300, 0x300 -> halt asserts only 1 cycle after the final 0x300; no trigger earlier.
- Pause and sticky: enable drops for 4 cycles mid-RUN -> counters hold. After DONE, toggling enable and fetching pass addresses changes nothing. clear -> IDLE with all outputs 0.
- Async reset mid-RUN: reset pulse between clock edges -> outputs zero immediately, without waiting for a clock edge; FSM returns to IDLE.
